// File: rtl/sar_search.sv
// Successive-approximation search controller driving the y operand of a magnitude comparator.
// Optional SAR_FLAGCHK_EN: require one-hot comparator flags on every probe.
module sar_search #(
  parameter int unsigned W  = 4,
  parameter int unsigned SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [W-1:0]  y,
  input  logic          xgy,
  input  logic          xsy,
  input  logic          xey,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  result,
  output logic [SW-1:0] steps
);

  typedef enum logic [0:0] {StIdle, StProbe} state_e;

  localparam logic [W-1:0]  YMax     = '1;
  localparam logic [W-1:0]  YInit    = YMax >> 1;
  localparam logic [W:0]    HiInit   = {1'b0, YMax};
  localparam logic [W:0]    One      = 1;
  localparam logic [SW-1:0] MaxSteps = SW'(W + 1);

  state_e        state_q;
  logic [W:0]    lo_q, hi_q;

  logic [W:0]    y_ext, lo_up, hi_dn;
  logic [W-1:0]  mid_gt, mid_lt;
  logic [SW-1:0] steps_nxt;
  logic          sel_eq, sel_gt, sel_lt, flag_bad, fault;

  // Flag decode
  always_comb begin
`ifdef SAR_FLAGCHK_EN
    sel_eq   = xey;
    sel_gt   = xgy;
    sel_lt   = xsy;
    flag_bad = !({xey, xgy, xsy} inside {3'b100, 3'b010, 3'b001});
`else
    // Priority xey > xgy > xsy; no flag at all behaves as x < y.
    sel_eq   = xey;
    sel_gt   = !xey && xgy;
    sel_lt   = !xey && !xgy;
    flag_bad = 1'b0;
`endif
  end

  // Candidate bounds, next guesses and fault detection for the current probe
  always_comb begin
    y_ext     = {1'b0, y};
    lo_up     = y_ext + One;
    hi_dn     = y_ext - One;
    mid_gt    = W'(lo_up + ((hi_q - lo_up) >> 1));
    mid_lt    = W'(lo_q + ((hi_dn - lo_q) >> 1));
    steps_nxt = steps + 1'b1;
    fault     = 1'b0;
    if (flag_bad) begin
      fault = 1'b1;
    end else if (sel_eq) begin
      fault = 1'b0;
    end else if (sel_gt) begin
      fault = (y == YMax) || (lo_up > hi_q) || (steps_nxt == MaxSteps);
    end else if (sel_lt) begin
      fault = (y == '0) || (lo_q > hi_dn) || (steps_nxt == MaxSteps);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lo_q    <= '0;
      hi_q    <= '0;
      y       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      steps   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A start coincident with the done/err pulse is dropped.
          if (start && !done && !err) begin
            state_q <= StProbe;
            busy    <= 1'b1;
            lo_q    <= '0;
            hi_q    <= HiInit;
            y       <= YInit;
            steps   <= '0;
            result  <= '0;
          end
        end
        StProbe: begin
          steps <= steps_nxt;
          if (fault) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (sel_eq) begin
            result  <= y;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (sel_gt) begin
            lo_q <= lo_up;
            y    <= mid_gt;
          end else begin
            hi_q <= hi_dn;
            y    <= mid_lt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: behavioural comparator plus hand-computed guess sequences.
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] y;
  logic       xgy, xsy, xey;
  logic       busy, done, err;
  logic [3:0] result;
  logic [2:0] steps;

  logic [3:0] x;
  int         mode;  // 0 ideal, 1 stuck xgy, 2 both xgy and xsy when y==11
  int         n_vec;
  int         n_miss;

  sar_search #(.W(4), .SW(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .y      (y),
    .xgy    (xgy),
    .xsy    (xsy),
    .xey    (xey),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result),
    .steps  (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    xgy = (x > y);
    xsy = (x < y);
    xey = (x == y);
    if (mode == 1) begin
      xgy = 1'b1;
      xsy = 1'b0;
      xey = 1'b0;
    end else if (mode == 2 && y == 4'd11) begin
      xgy = 1'b1;
      xsy = 1'b1;
      xey = 1'b0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle_regs(input string tag);
    check({tag, ".y"}, y, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".err"}, err, 0);
    check({tag, ".result"}, result, 0);
    check({tag, ".steps"}, steps, 0);
  endtask

  // ys holds expected guesses, first probe in the top nibble.
  task automatic run(input string tag, input logic [3:0] xv, input int md, input int exp_n,
                     input logic exp_err, input int exp_res, input logic [19:0] ys);
    int k;
    x    = xv;
    mode = md;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, ".busy0"}, busy, 1);
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i <= exp_n) check($sformatf("%s.y%0d", tag, i), y, ys[19 - 4*(i-1) -: 4]);
      @(posedge clk);
      #1;
      if (done || err) begin
        k = i;
        break;
      end
    end
    check({tag, ".edge"}, k, exp_n);
    check({tag, ".done"}, done, exp_err ? 0 : 1);
    check({tag, ".err"}, err, exp_err ? 1 : 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".steps"}, steps, exp_n);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, done | err, 0);
    check({tag, ".hold"}, result, exp_res);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    x      = 4'd0;
    mode   = 0;
    start  = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_idle_regs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run("x9",  4'd9,  0, 3, 1'b0, 9,  {4'd7, 4'd11, 4'd9, 4'd0, 4'd0});
    run("x15", 4'd15, 0, 5, 1'b0, 15, {4'd7, 4'd11, 4'd13, 4'd14, 4'd15});
    run("x0",  4'd0,  0, 4, 1'b0, 0,  {4'd7, 4'd3, 4'd1, 4'd0, 4'd0});

    // First probe matches; a start during the done pulse must be dropped.
    x    = 4'd7;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("x7.busy0", busy, 1);
    @(posedge clk);
    #1;
    check("x7.done", done, 1);
    check("x7.busy", busy, 0);
    check("x7.result", result, 7);
    check("x7.steps", steps, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("x7.start_in_done", busy, 0);
    check("x7.steps_hold", steps, 1);

    // Asynchronous reset in the middle of an x=15 search.
    x    = 4'd15;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle_regs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run("after_rst", 4'd9, 0, 3, 1'b0, 9, {4'd7, 4'd11, 4'd9, 4'd0, 4'd0});

    run("stuck", 4'd3, 1, 5, 1'b1, 0, {4'd7, 4'd11, 4'd13, 4'd14, 4'd15});

`ifdef SAR_FLAGCHK_EN
    run("dbl", 4'd15, 2, 2, 1'b1, 0, {4'd7, 4'd11, 4'd0, 4'd0, 4'd0});
`else
    run("dbl", 4'd15, 2, 5, 1'b0, 15, {4'd7, 4'd11, 4'd13, 4'd14, 4'd15});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
